time_set_ctrl: RTL and testbench

//  Two-button time-setting controller for the binary clock. Debounces MODE/INC buttons, steps

---
 rtl/binary_clock_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/time_set_ctrl.sv | 173 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_clock_pkg.sv
// Shared types and limits for the binary clock: set-state encoding, edit-field codes,
// field widths and maxima, plus a wrapping increment helper used by the time setter.
package binary_clock_pkg;

  localparam int HOURS_W     = 5;
  localparam int MINSEC_W    = 6;
  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;
  localparam int SECONDS_MAX = 59;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } set_state_t;

  typedef enum logic [1:0] {
    EF_NONE    = 2'd0,
    EF_HOURS   = 2'd1,
    EF_MINUTES = 2'd2,
    EF_SECONDS = 2'd3
  } edit_field_t;

  // Increment that wraps to zero past max_v; no carry into neighbouring fields.
  function automatic logic [MINSEC_W-1:0] wrap_inc(input logic [MINSEC_W-1:0] v,
                                                   input logic [MINSEC_W-1:0] max_v);
    return (v >= max_v) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer and a one-cycle press pulse
// on each accepted released->pressed transition. Raw edge to pulse latency is 2 + DEBOUNCE_CYCLES.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // r_cnt counts consecutive synchronized samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Two-button time-setting controller: edits hours/minutes/seconds on shadow registers while
// holding the clock, then commits with a one-cycle load pulse. SET_TIMEOUT_EN enables edit abort.
module time_set_ctrl
  import binary_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_SECS    = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_tick,
  input  logic                btn_mode,
  input  logic                btn_inc,
  input  logic [HOURS_W-1:0]  cur_hours,
  input  logic [MINSEC_W-1:0] cur_minutes,
  input  logic [MINSEC_W-1:0] cur_seconds,
  output logic                hold,
  output logic                load,
  output logic [HOURS_W-1:0]  load_hours,
  output logic [MINSEC_W-1:0] load_minutes,
  output logic [MINSEC_W-1:0] load_seconds,
  output logic [1:0]          edit_field,
  output logic                blink
);

  logic [1:0] w_raw;
  logic [1:0] w_press;
  logic       w_mode_press;
  logic       w_inc_press;

  assign w_raw = {btn_inc, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (w_raw[gi]),
        .o_press(w_press[gi])
      );
    end
  endgenerate

  assign w_mode_press = w_press[0];
  assign w_inc_press  = w_press[1];

  set_state_t          r_state;
  logic [HOURS_W-1:0]  r_hours;
  logic [MINSEC_W-1:0] r_minutes;
  logic [MINSEC_W-1:0] r_seconds;
  logic                r_hold;
  logic                r_load;
  edit_field_t         r_edit_field;
  logic                r_blink;

  logic [MINSEC_W-1:0] w_hours_inc;
  logic [MINSEC_W-1:0] w_minutes_inc;
  logic [MINSEC_W-1:0] w_seconds_inc;

  assign w_hours_inc   = wrap_inc({1'b0, r_hours}, MINSEC_W'(HOURS_MAX));
  assign w_minutes_inc = wrap_inc(r_minutes, MINSEC_W'(MINUTES_MAX));
  assign w_seconds_inc = wrap_inc(r_seconds, MINSEC_W'(SECONDS_MAX));

`ifdef SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_SECS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_SECS - 1);
  logic [TO_W-1:0] r_to_cnt;
`else
  generate
    if (TIMEOUT_SECS < 1) begin : g_timeout_unused
    end
  endgenerate
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_hours      <= '0;
      r_minutes    <= '0;
      r_seconds    <= '0;
      r_hold       <= 1'b0;
      r_load       <= 1'b0;
      r_edit_field <= EF_NONE;
      r_blink      <= 1'b0;
`ifdef SET_TIMEOUT_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_load <= 1'b0;
      case (r_state)
        RUN: begin
          r_hold       <= 1'b0;
          r_edit_field <= EF_NONE;
          r_blink      <= 1'b0;
          if (w_mode_press) begin
            r_state      <= SET_H;
            r_hours      <= cur_hours;
            r_minutes    <= cur_minutes;
            r_seconds    <= cur_seconds;
            r_hold       <= 1'b1;
            r_edit_field <= EF_HOURS;
          end
        end
        SET_H, SET_M, SET_S: begin
          if (s_tick) r_blink <= ~r_blink;
          // MODE takes priority; a coincident INC press is dropped.
          if (w_mode_press) begin
            case (r_state)
              SET_H: begin
                r_state      <= SET_M;
                r_edit_field <= EF_MINUTES;
              end
              SET_M: begin
                r_state      <= SET_S;
                r_edit_field <= EF_SECONDS;
              end
              default: begin
                r_state      <= COMMIT;
                r_edit_field <= EF_NONE;
                r_blink      <= 1'b0;
                r_load       <= 1'b1;
              end
            endcase
          end else if (w_inc_press) begin
            case (r_state)
              SET_H:   r_hours   <= w_hours_inc[HOURS_W-1:0];
              SET_M:   r_minutes <= w_minutes_inc;
              default: r_seconds <= w_seconds_inc;
            endcase
          end
`ifdef SET_TIMEOUT_EN
          else if (s_tick && (r_to_cnt == TO_LAST)) begin
            r_state      <= RUN;
            r_hold       <= 1'b0;
            r_edit_field <= EF_NONE;
            r_blink      <= 1'b0;
          end
`endif
        end
        COMMIT: begin
          r_state <= RUN;
          r_hold  <= 1'b0;
        end
        default: begin
          r_state      <= RUN;
          r_hold       <= 1'b0;
          r_edit_field <= EF_NONE;
          r_blink      <= 1'b0;
        end
      endcase
`ifdef SET_TIMEOUT_EN
      if ((r_state == SET_H) || (r_state == SET_M) || (r_state == SET_S)) begin
        if (w_mode_press || w_inc_press) r_to_cnt <= '0;
        else if (s_tick)                 r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
`endif
    end
  end

  assign hold         = r_hold;
  assign load         = r_load;
  assign load_hours   = r_hours;
  assign load_minutes = r_minutes;
  assign load_seconds = r_seconds;
  assign edit_field   = r_edit_field;
  assign blink        = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against a press-level reference model of the set sequence.
// Honours SET_TIMEOUT_EN (timeout of TO ticks) when the macro is defined for both files.
module tb_time_set_ctrl;

  localparam int D  = 8;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [5:0] cur_seconds = '0;
  logic       hold, load, blink;
  logic [4:0] load_hours;
  logic [5:0] load_minutes, load_seconds;
  logic [1:0] edit_field;

  time_set_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_SECS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .hold(hold), .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
    .load_seconds(load_seconds), .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: stage 0 = running, 1/2/3 = editing h/m/s; commit is instantaneous here.
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0, m_blink = 0, m_to = 0;
  int m_loads = 0, e_h = 0, e_m = 0, e_s = 0;

  task automatic model_mode();
    if (m_st == 0) begin
      m_st = 1; m_h = cur_hours; m_m = cur_minutes; m_s = cur_seconds; m_blink = 0;
    end else if (m_st < 3) begin
      m_st++;
    end else begin
      m_loads++; e_h = m_h; e_m = m_m; e_s = m_s; m_st = 0; m_blink = 0;
    end
    m_to = 0;
  endtask

  task automatic model_inc();
    case (m_st)
      1: m_h = (m_h + 1) % 24;
      2: m_m = (m_m + 1) % 60;
      3: m_s = (m_s + 1) % 60;
      default: ;
    endcase
    m_to = 0;
  endtask

  task automatic model_tick();
    if (m_st != 0) begin
      m_blink ^= 1;
`ifdef SET_TIMEOUT_EN
      m_to++;
      if (m_to == TO) begin m_st = 0; m_blink = 0; m_to = 0; end
`endif
    end
  endtask

  // Load monitor: counts pulses, captures committed values, checks hold around the pulse.
  int mon_loads = 0, mon_h = 0, mon_m = 0, mon_s = 0;
  logic load_d = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_d) check("hold_after_load", {31'd0, hold}, 32'd0);
      if (load) begin
        mon_loads++; mon_h = load_hours; mon_m = load_minutes; mon_s = load_seconds;
        check("hold_at_load", {31'd0, hold}, 32'd1);
      end
      load_d = load;
    end else begin
      load_d = 1'b0;
    end
  end

  task automatic check_state(input string tag);
    txn++;
    check({tag, ".edit_field"}, edit_field, m_st);
    check({tag, ".hold"}, hold, (m_st != 0));
    check({tag, ".load"}, load, 0);
    check({tag, ".blink"}, blink, m_blink);
    if (m_st != 0) begin
      check({tag, ".hours"}, load_hours, m_h);
      check({tag, ".minutes"}, load_minutes, m_m);
      check({tag, ".seconds"}, load_seconds, m_s);
    end
    check({tag, ".load_count"}, mon_loads, m_loads);
    if (m_loads > 0) begin
      check({tag, ".commit_h"}, mon_h, e_h);
      check({tag, ".commit_m"}, mon_m, e_m);
      check({tag, ".commit_s"}, mon_s, e_s);
    end
    $display("txn %0d %s stage=%0d shadow=%0d:%0d:%0d blink=%0d loads=%0d",
             txn, tag, m_st, m_h, m_m, m_s, m_blink, m_loads);
  endtask

  task automatic press(input bit m, input bit i);
    @(negedge clk); btn_mode = m; btn_inc = i;
    repeat (D + 4) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (D + 4) @(negedge clk);
    if (m) model_mode();
    else if (i) model_inc();
    check_state(m && i ? "both" : (m ? "mode" : "inc"));
  endtask

  task automatic glitch(input int len);
    @(negedge clk); btn_inc = 1'b1;
    repeat (len) @(negedge clk);
    btn_inc = 1'b0;
    repeat (D + 4) @(negedge clk);
    if (len >= D) model_inc();
    check_state($sformatf("inc_pulse%0d", len));
  endtask

  task automatic tick();
    @(negedge clk); s_tick = 1'b1;
    @(negedge clk); s_tick = 1'b0;
    model_tick();
    check_state("tick");
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    @(negedge clk);
    cur_hours = 5'(h); cur_minutes = 6'(mi); cur_seconds = 6'(s);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".hold"}, hold, 0);
    check({tag, ".load"}, load, 0);
    check({tag, ".load_hours"}, load_hours, 0);
    check({tag, ".load_minutes"}, load_minutes, 0);
    check({tag, ".load_seconds"}, load_seconds, 0);
    check({tag, ".edit_field"}, edit_field, 0);
    check({tag, ".blink"}, blink, 0);
  endtask

  task automatic finish_edit();
    while (m_st != 0) press(1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int loads_before;

    // Reset values
    #2; check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state("post_reset");

    // Raw MODE edge to edit_field update: synchronizer + debounce + FSM register
    set_cur(4, 5, 6);
    @(negedge clk); btn_mode = 1'b1;
    n = 0;
    while (n < 40 && edit_field != 2'd1) begin @(posedge clk); n++; #1; end
    check("press_latency", n, D + 3);
    @(negedge clk); btn_mode = 1'b0;
    repeat (D + 4) @(negedge clk);
    model_mode(); check_state("mode_latency");

    // Bounce on INC in SET_H: D-1 cycles rejected, D cycles accepted
    glitch(D - 1);
    check("glitch_rejected", load_hours, 4);
    glitch(D);
    check("stable_accepted", load_hours, 5);
    finish_edit();

    // Full set sequence from 10:20:30
    set_cur(10, 20, 30);
    loads_before = mon_loads;
    press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (40) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("fullset.loads", mon_loads, loads_before + 1);
    check("fullset.h", mon_h, 13);
    check("fullset.m", mon_m, 0);
    check("fullset.s", mon_s, 31);

    // Wraps without carry
    set_cur(23, 45, 59);
    press(1'b1, 1'b0); press(1'b0, 1'b1);
    check("wrap_hours", load_hours, 0);
    press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1);
    check("wrap_seconds", load_seconds, 0);
    check("wrap_minutes_kept", load_minutes, 45);
    press(1'b1, 1'b0);

    // MODE and INC together in SET_H: MODE wins
    set_cur(7, 8, 9);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("both.edit_field", edit_field, 2);
    check("both.hours_kept", load_hours, 7);
    finish_edit();

    // Three quiet seconds in SET_H: abort with timeout, stay otherwise
    loads_before = mon_loads;
    press(1'b1, 1'b0);
    repeat (3) tick();
`ifdef SET_TIMEOUT_EN
    check("timeout.edit_field", edit_field, 0);
    check("timeout.hold", hold, 0);
`else
    check("no_timeout.edit_field", edit_field, 1);
`endif
    check("timeout.no_load", mon_loads, loads_before);
    finish_edit();

    // Reset mid-SET_M with minutes edited to 12
    set_cur(10, 11, 5);
    press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1);
    check("pre_reset.minutes", load_minutes, 12);
    loads_before = mon_loads;
    @(negedge clk); rst_n = 1'b0;
    #1; check_zero_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_blink = 0; m_to = 0;
    repeat (2) @(negedge clk);
    check("midreset.no_load", mon_loads, loads_before);
    check_state("after_midreset");

    // Randomized mix of presses, bounces and ticks
    for (int k = 0; k < 120; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
              int'($urandom_range(0, 59)));
      case (r)
        0, 1:       press(1'b1, 1'b0);
        2, 3, 4, 5: press(1'b0, 1'b1);
        6:          press(1'b1, 1'b1);
        7:          glitch(int'($urandom_range(1, D + 3)));
        default:    tick();
      endcase
    end
    finish_edit();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
